// File: rtl/aud_rec_sram_writer_if.sv
// SRAM write port of the audio recorder: word address, sample word and write strobe.
interface aud_rec_sram_writer_if;
    // o_we is a one-cycle strobe qualifying o_address/o_data; the SRAM has no ready
    // and must accept every strobe, so there is no backpressure on this port.
    logic [19:0] o_address;
    logic [15:0] o_data;
    logic        o_we;

    modport master (output o_address, output o_data, output o_we);
    modport slave  (input  o_address, input  o_data, input  o_we);
endinterface

// File: rtl/aud_rec_sram_writer.sv
// Captures WM8731 I2S ADC samples (left only, or left+right with AUD_REC_STEREO_EN)
// and writes one 16-bit word per sample to consecutive SRAM addresses.
module aud_rec_sram_writer #(
    parameter logic [19:0] ADDR_MAX = 20'hFFFFF
) (
    input  logic                         i_AUD_BCLK,
    input  logic                         i_rst_n,
    input  logic                         i_lrc,
    input  logic                         i_data,
    input  logic                         i_start,
    input  logic                         i_pause,
    input  logic                         i_stop,
    aud_rec_sram_writer_if.master        sram,
    output logic [19:0]                  o_length,
    output logic                         o_recording,
    output logic                         o_full,
    output logic [2:0]                   o_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LR, S_CAPTURE, S_WRITE, S_PAUSED, S_FULL
    } state_t;

    state_t      state_q, state_d;
    logic        lrc_d_q, lrc_d_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [19:0] addr_q, addr_d;
    logic [19:0] len_q, len_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d;
    logic        rec_q, rec_d;
    logic        full_q, full_d;
    logic        rst_meta_q, rst_core_q;
    logic        frame_start;

    // Reset asserts immediately but is released two clock edges after i_rst_n drops.
    always_ff @(posedge i_AUD_BCLK or posedge i_rst_n) begin
        if (i_rst_n) begin
            rst_meta_q <= 1'b1;
            rst_core_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_core_q <= rst_meta_q;
        end
    end

`ifdef AUD_REC_STEREO_EN
    assign frame_start = lrc_d_q ^ i_lrc;
`else
    assign frame_start = lrc_d_q & ~i_lrc;
`endif

    always_comb begin
        state_d   = state_q;
        lrc_d_d   = i_lrc;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        len_d     = len_q;
        data_d    = data_q;
        we_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = 20'd0;
                    len_d   = 20'd0;
                    state_d = S_WAIT_LR;
                end
            end
            S_WAIT_LR: begin
                if (i_stop)           state_d = S_IDLE;
                else if (i_pause)     state_d = S_PAUSED;
                else if (frame_start) begin
                    // This cycle is the I2S one-bit delay slot; MSB arrives next cycle.
                    state_d   = S_CAPTURE;
                    bit_cnt_d = 4'd0;
                end
            end
            S_CAPTURE: begin
                if (i_stop)       state_d = S_IDLE;
                else if (i_pause) state_d = S_PAUSED;
                else begin
                    shift_d   = {shift_q[14:0], i_data};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        state_d = S_WRITE;
                        data_d  = shift_d;
                        we_d    = 1'b1;
                        len_d   = len_q + 20'd1;
                    end
                end
            end
            S_WRITE: begin
                // The strobe is already on the bus this cycle, so a pause still keeps the word.
                if (i_stop)                    state_d = S_IDLE;
                else if (addr_q == ADDR_MAX)   state_d = S_FULL;
                else begin
                    addr_d  = addr_q + 20'd1;
                    state_d = i_pause ? S_PAUSED : S_WAIT_LR;
                end
            end
            S_PAUSED: begin
                if (i_stop)       state_d = S_IDLE;
                else if (i_start) state_d = S_WAIT_LR;
            end
            S_FULL: begin
                if (i_stop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        rec_d  = (state_d == S_WAIT_LR) || (state_d == S_CAPTURE) || (state_d == S_WRITE);
        full_d = (state_d == S_FULL);
    end

    always_ff @(posedge i_AUD_BCLK or posedge rst_core_q) begin
        if (rst_core_q) begin
            state_q   <= S_IDLE;
            lrc_d_q   <= 1'b0;
            shift_q   <= 16'd0;
            bit_cnt_q <= 4'd0;
            addr_q    <= 20'd0;
            len_q     <= 20'd0;
            data_q    <= 16'd0;
            we_q      <= 1'b0;
            rec_q     <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lrc_d_q   <= lrc_d_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            data_q    <= data_d;
            we_q      <= we_d;
            rec_q     <= rec_d;
            full_q    <= full_d;
        end
    end

    assign sram.o_address = addr_q;
    assign sram.o_data    = data_q;
    assign sram.o_we      = we_q;
    assign o_length       = len_q;
    assign o_recording    = rec_q;
    assign o_full         = full_q;
    assign o_state        = state_q;
endmodule

// File: tb/tb_aud_rec_sram_writer.sv
// Randomized scoreboard bench for aud_rec_sram_writer (ADDR_MAX=3); define
// AUD_REC_STEREO_EN for both bench and RTL to exercise the stereo build.
module tb_aud_rec_sram_writer;
    localparam logic [19:0] TB_ADDR_MAX = 20'd3;

    logic        clk;
    logic        i_rst_n;
    logic        i_lrc;
    logic        i_data;
    logic        i_start;
    logic        i_pause;
    logic        i_stop;
    logic [19:0] o_length;
    logic        o_recording;
    logic        o_full;
    logic [2:0]  o_state;

    aud_rec_sram_writer_if sram_if();

    aud_rec_sram_writer #(.ADDR_MAX(TB_ADDR_MAX)) dut (
        .i_AUD_BCLK (clk),
        .i_rst_n    (i_rst_n),
        .i_lrc      (i_lrc),
        .i_data     (i_data),
        .i_start    (i_start),
        .i_pause    (i_pause),
        .i_stop     (i_stop),
        .sram       (sram_if),
        .o_length   (o_length),
        .o_recording(o_recording),
        .o_full     (o_full),
        .o_state    (o_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    // {cycle[31:0], length[19:0], address[19:0], data[15:0]}
    logic [87:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic [87:0] e;
        if (sram_if.o_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 64'(sram_if.o_address), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("we_cycle",   64'(cyc),               64'(e[87:56]));
                chk("we_length",  64'(o_length),          64'(e[55:36]));
                chk("we_address", 64'(sram_if.o_address), 64'(e[35:16]));
                chk("we_data",    64'(sram_if.o_data),    64'(e[15:0]));
            end
        end
    end

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_REC, M_PAUSED, M_FULL} mdl_st_t;
    mdl_st_t     mdl_st   = M_IDLE;
    logic [19:0] mdl_addr = 20'd0;
    logic [19:0] mdl_len  = 20'd0;

    task automatic mdl_ctrl(input logic [2:0] ctl);
        if (ctl[2]) begin
            mdl_st = M_IDLE;
        end else if (ctl[1]) begin
            if (mdl_st == M_REC) mdl_st = M_PAUSED;
        end else if (ctl[0]) begin
            if (mdl_st == M_IDLE) begin
                mdl_addr = 20'd0;
                mdl_len  = 20'd0;
                mdl_st   = M_REC;
            end else if (mdl_st == M_PAUSED) begin
                mdl_st = M_REC;
            end
        end
    endtask

    task automatic mdl_write(input logic [15:0] d, input int t);
        exp_q.push_back({32'(t), mdl_len + 20'd1, mdl_addr, d});
        mdl_len = mdl_len + 20'd1;
        if (mdl_addr == TB_ADDR_MAX) mdl_st = M_FULL;
        else mdl_addr = mdl_addr + 20'd1;
    endtask

    task automatic check_status();
        chk("length",    64'(o_length),    64'(mdl_len));
        chk("recording", 64'(o_recording), 64'(mdl_st == M_REC));
        chk("full",      64'(o_full),      64'(mdl_st == M_FULL));
    endtask

    // ---------------- drivers ----------------
    task automatic drive_cycle(input logic lrc, input logic d, input logic [2:0] ctl);
        i_lrc = lrc;
        i_data = d;
        {i_stop, i_pause, i_start} = ctl;
        @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] ctl);
        mdl_ctrl(ctl);
        drive_cycle(1'b1, 1'($urandom), ctl);
        drive_cycle(1'b1, 1'($urandom), 3'b000);
        check_status();
    endtask

    // One 64-clock frame: left half (LRC low) then right half, each a delay slot,
    // 16 data bits MSB first and 15 don't-care bits. ev fires on cycle ev_cyc (0..16).
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input logic [2:0] ev, input int ev_cyc);
        int fs;
        bit was_rec;
        logic b;
        fs = cyc;
        was_rec = (mdl_st == M_REC);
        if (ev != 3'b000) mdl_ctrl(ev);
        if (was_rec && mdl_st == M_REC) mdl_write(l, fs + 17);
`ifdef AUD_REC_STEREO_EN
        if (mdl_st == M_REC) mdl_write(r, fs + 49);
`endif
        for (int c = 0; c < 64; c++) begin
            if (c >= 1 && c <= 16)       b = l[16 - c];
            else if (c >= 33 && c <= 48) b = r[48 - c];
            else                         b = 1'($urandom);
            drive_cycle(c >= 32, b, (c == ev_cyc) ? ev : 3'b000);
        end
        check_status();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] ev;
        i_rst_n = 1'b1;
        i_lrc   = 1'b1;
        i_data  = 1'b0;
        i_start = 1'b0;
        i_pause = 1'b0;
        i_stop  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_address",   64'(sram_if.o_address), 64'd0);
        chk("rst_data",      64'(sram_if.o_data),    64'd0);
        chk("rst_we",        64'(sram_if.o_we),      64'd0);
        chk("rst_length",    64'(o_length),          64'd0);
        chk("rst_recording", 64'(o_recording),       64'd0);
        chk("rst_full",      64'(o_full),            64'd0);
        i_rst_n = 1'b0;
        repeat (4) drive_cycle(1'b1, 1'b0, 3'b000);

        // single left sample
        pulse(3'b001);
        send_frame(16'hA5C3, 16'h3C5A, 3'b000, 0);

        // three frames from a fresh start
        pulse(3'b100);
        pulse(3'b001);
        send_frame(16'h0001, 16'h1111, 3'b000, 0);
        send_frame(16'h8000, 16'h2222, 3'b000, 0);
        send_frame(16'hFFFF, 16'h3333, 3'b000, 0);

        // pause mid-capture discards the sample; resume continues at the next address
        pulse(3'b100);
        pulse(3'b001);
        send_frame(16'h1357, 16'h2468, 3'b000, 0);
        send_frame(16'hBEEF, 16'hCAFE, 3'b010, 8);
        pulse(3'b001);
        send_frame(16'h7E57, 16'h4321, 3'b000, 0);

        // fill to ADDR_MAX, then start/pause are ignored and only stop leaves FULL
        pulse(3'b100);
        pulse(3'b001);
        for (int i = 0; i < 5; i++) send_frame(16'(16'h1000 + i), 16'(16'h2000 + i), 3'b000, 0);
        pulse(3'b001);
        pulse(3'b010);
        pulse(3'b100);

        // stop and start together during capture: stop wins, no write
        pulse(3'b001);
        send_frame(16'h5A5A, 16'hA5A5, 3'b101, 8);

        // stereo pair (right word stored only in the stereo build)
        pulse(3'b001);
        send_frame(16'h1234, 16'h5678, 3'b000, 0);

        // reset in the middle of capture
        pulse(3'b100);
        pulse(3'b001);
        send_frame(16'h9C3A, 16'h0F0F, 3'b000, 0);
        for (int c = 0; c <= 5; c++) drive_cycle(c >= 32, 1'($urandom), 3'b000);
        #2 i_rst_n = 1'b1;
        #1;
        chk("midrst_address",   64'(sram_if.o_address), 64'd0);
        chk("midrst_data",      64'(sram_if.o_data),    64'd0);
        chk("midrst_we",        64'(sram_if.o_we),      64'd0);
        chk("midrst_length",    64'(o_length),          64'd0);
        chk("midrst_recording", 64'(o_recording),       64'd0);
        chk("midrst_full",      64'(o_full),            64'd0);
        repeat (3) @(negedge clk);
        i_rst_n  = 1'b0;
        mdl_st   = M_IDLE;
        mdl_addr = 20'd0;
        mdl_len  = 20'd0;
        repeat (4) drive_cycle(1'b1, 1'b0, 3'b000);
        check_status();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (mdl_st == M_IDLE && $urandom_range(0, 1) == 1) begin
                pulse(3'b001);
            end else if ($urandom_range(0, 4) == 0) begin
                pulse(3'($urandom_range(1, 7)));
            end else begin
                ev = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                send_frame(16'($urandom), 16'($urandom), ev, int'($urandom_range(0, 16)));
            end
        end

        repeat (8) drive_cycle(1'b1, 1'b0, 3'b000);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
